playfield_scroll_ctrl: RTL and testbench

Sequencer for the playfield horizontal scroll datapath. Keeps the horizontal/vertical beam counters on MCKR and accepts CPU scroll writes through a req/ack handshake. Each new 9-bit scroll value is held pending and transferred to the scroll latch (VBD bus plus HSCRLD_b strobe) only at a fixed column, so a write never tears a line. Also generates the per-line PFHST_b counter-load pulse and the 4H phase that clock the playfield horizontal counters.

---
 rtl/playfield_scroll_ctrl.sv | 119 +++++++++++
 tb/tb_playfield_scroll_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/playfield_scroll_ctrl.sv
// Playfield horizontal scroll sequencer: beam counters, CPU scroll write handshake and
// tear-free transfer of the pending scroll value to the scroll latch at a fixed column.
module playfield_scroll_ctrl #(
  parameter int unsigned H_TOTAL   = 456,
  parameter int unsigned V_TOTAL   = 262,
  parameter int unsigned LOAD_COL  = 440,
  parameter int unsigned PFHST_COL = 448
) (
  input  logic       MCKR,
  input  logic       reset_b,
  input  logic       wr_req,
  input  logic [8:0] wr_data,
  input  logic       frame_mode,
  output logic       wr_ack,
  output logic       pending,
  output logic [8:0] VBD,
  output logic       HSCRLD_b,
  output logic       PFHST_b,
  output logic       H4,
  output logic [8:0] hcount,
  output logic [8:0] vcount
);

  localparam logic [8:0] HLast    = 9'(H_TOTAL - 1);
  localparam logic [8:0] VLast    = 9'(V_TOTAL - 1);
  localparam logic [8:0] LoadCol  = 9'(LOAD_COL);
  localparam logic [8:0] PfhstCol = 9'(PFHST_COL);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStrobe = 2'd1,
    StHold   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] hcount_q, hcount_d;
  logic [8:0] vcount_q, vcount_d;
  logic [8:0] pend_val_q, pend_val_d;
  logic [8:0] vbd_q, vbd_d;
  logic       pending_q, pending_d;
  logic       ack_q, ack_d;
  logic       pfhst_b_q, pfhst_b_d;
  logic       h_wrap;
  logic       accept;
  logic       apply;

  // Beam counters
  always_comb begin
    h_wrap   = (hcount_q == HLast);
    hcount_d = h_wrap ? 9'd0 : hcount_q + 9'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = (vcount_q == VLast) ? 9'd0 : vcount_q + 9'd1;
    end
  end

  // Decisions use the next beam position so every registered output lines up with hcount.
  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hcount_d == LoadCol && pending_q && (!frame_mode || vcount_d == 9'd0)) begin
          apply   = 1'b1;
          state_d = StStrobe;
        end
      end
      StStrobe: state_d = StHold;
      StHold: begin
        if (h_wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // An apply on the accept edge consumes the old value; the new one stays pending.
  always_comb begin
    accept     = wr_req && !ack_q;
    ack_d      = accept;
    pend_val_d = accept ? wr_data : pend_val_q;
    pending_d  = accept || (pending_q && !apply);
    vbd_d      = apply ? pend_val_q : vbd_q;
    pfhst_b_d  = (hcount_d != PfhstCol);
  end

  always_ff @(posedge MCKR) begin
    if (!reset_b) begin
      state_q    <= StIdle;
      hcount_q   <= 9'd0;
      vcount_q   <= 9'd0;
      pend_val_q <= 9'd0;
      vbd_q      <= 9'd0;
      pending_q  <= 1'b1;
      ack_q      <= 1'b0;
      pfhst_b_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      pend_val_q <= pend_val_d;
      vbd_q      <= vbd_d;
      pending_q  <= pending_d;
      ack_q      <= ack_d;
      pfhst_b_q  <= pfhst_b_d;
    end
  end

  assign wr_ack   = ack_q;
  assign pending  = pending_q;
  assign VBD      = vbd_q;
  assign HSCRLD_b = (state_q != StStrobe);
  assign PFHST_b  = pfhst_b_q;
  assign H4       = hcount_q[2];
  assign hcount   = hcount_q;
  assign vcount   = vcount_q;

endmodule

// File: tb/tb_playfield_scroll_ctrl.sv
// Self-checking bench for playfield_scroll_ctrl: directed scenarios plus random writes, every
// cycle compared against a cycle-count based reference model.
module tb_playfield_scroll_ctrl;

  localparam int HT = 456;
  localparam int VT = 16;
  localparam int LC = 440;
  localparam int PC = 448;

  logic       clk = 1'b0;
  logic       reset_b, wr_req, frame_mode;
  logic [8:0] wr_data;
  logic       wr_ack, pending, HSCRLD_b, PFHST_b, H4;
  logic [8:0] VBD, hcount, vcount;

  int tests = 0;
  int fails = 0;

  // Reference model: beam position derived from cycles since reset
  int         m_t = 0;
  bit         m_pend = 1'b1;
  logic [8:0] m_pv = 9'd0;
  logic [8:0] m_vbd = 9'd0;
  bit         m_ack = 1'b0;
  bit         m_strobe = 1'b0;
  bit         g_fm = 1'b0;

  always #5 clk = ~clk;

  playfield_scroll_ctrl #(
    .H_TOTAL  (HT),
    .V_TOTAL  (VT),
    .LOAD_COL (LC),
    .PFHST_COL(PC)
  ) dut (
    .MCKR      (clk),
    .reset_b   (reset_b),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .frame_mode(frame_mode),
    .wr_ack    (wr_ack),
    .pending   (pending),
    .VBD       (VBD),
    .HSCRLD_b  (HSCRLD_b),
    .PFHST_b   (PFHST_b),
    .H4        (H4),
    .hcount    (hcount),
    .vcount    (vcount)
  );

  function automatic int cur_h();
    return m_t % HT;
  endfunction

  function automatic int cur_v();
    return (m_t / HT) % VT;
  endfunction

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s t=%0d: got %0h expected %0h", tag, m_t, got, exp);
    end
  endtask

  task automatic check_all();
    int h;
    h = cur_h();
    chk("hcount", hcount, 9'(h));
    chk("vcount", vcount, 9'(cur_v()));
    chk("HSCRLD_b", {8'd0, HSCRLD_b}, {8'd0, !m_strobe});
    chk("PFHST_b", {8'd0, PFHST_b}, {8'd0, h != PC});
    chk("VBD", VBD, m_vbd);
    chk("pending", {8'd0, pending}, {8'd0, m_pend});
    chk("wr_ack", {8'd0, wr_ack}, {8'd0, m_ack});
    chk("H4", {8'd0, H4}, {8'd0, ((h / 4) % 2) == 1});
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare.
  task automatic cyc(input bit rst, input bit req, input logic [8:0] d);
    bit acc, app;
    reset_b    = !rst;
    wr_req     = req;
    wr_data    = d;
    frame_mode = g_fm;
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_pend = 1'b1; m_pv = 9'd0; m_vbd = 9'd0; m_ack = 1'b0; m_strobe = 1'b0;
    end else begin
      m_t++;
      acc = req && !m_ack;
      app = (cur_h() == LC) && m_pend && (!g_fm || cur_v() == 0);
      m_strobe = app;
      if (app) begin
        m_vbd  = m_pv;
        m_pend = 1'b0;
      end
      if (acc) begin
        m_pv   = d;
        m_pend = 1'b1;
      end
      m_ack = acc;
    end
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 9'd0);
  endtask

  task automatic wait_h(input int target);
    for (int i = 0; i < HT && cur_h() != target; i++) cyc(1'b0, 1'b0, 9'd0);
  endtask

  task automatic wait_v(input int target);
    for (int i = 0; i < HT * VT && cur_v() != target; i++) cyc(1'b0, 1'b0, 9'd0);
  endtask

  task automatic write(input logic [8:0] d);
    cyc(1'b0, 1'b1, d);
    cyc(1'b0, 1'b0, 9'd0);
  endtask

  initial begin
    // Reset with a request held: never acked
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 9'h1AB);
    chk("rst_hcount", hcount, 9'd0);
    chk("rst_vbd", VBD, 9'd0);
    // Line 0: initial load of 0 at LOAD_COL
    wait_h(LC);
    chk("init_strobe", {8'd0, HSCRLD_b}, 9'd0);
    chk("init_vbd", VBD, 9'd0);
    idle(HT - LC + 2);
    chk("line1_vcount", vcount, 9'd1);

    // Single write applied same line
    wait_h(100);
    write(9'h123);
    wait_h(LC);
    chk("w123_vbd", VBD, 9'h123);
    idle(HT - LC + 2);

    // Two writes in one line, last one wins
    wait_h(50);
    write(9'h010);
    wait_h(200);
    write(9'h1FF);
    wait_h(LC + 1);
    chk("w1ff_vbd", VBD, 9'h1FF);
    idle(HT - LC + 2);

    // Accept and apply on the same edge
    wait_h(300);
    write(9'h0AA);
    wait_h(LC - 1);
    cyc(1'b0, 1'b1, 9'h055);
    chk("coll_vbd", VBD, 9'h0AA);
    chk("coll_pending", {8'd0, pending}, 9'd1);
    cyc(1'b0, 1'b0, 9'd0);
    idle(HT - LC);
    wait_h(LC);
    chk("coll_next_vbd", VBD, 9'h055);

    // Frame mode: apply only on line 0
    g_fm = 1'b1;
    wait_v(5);
    wait_h(20);
    write(9'h077);
    wait_v(0);
    wait_h(LC);
    chk("frame_vbd", VBD, 9'h077);
    idle(30);
    g_fm = 1'b0;

    // Random writes, including held requests and frame_mode changes
    for (int i = 0; i < 6000; i++) begin
      if (i % 700 == 0) g_fm = ($urandom_range(0, 3) == 0);
      cyc(1'b0, $urandom_range(0, 15) == 0, 9'($urandom));
    end
    g_fm = 1'b0;

    // Reset in the middle of a strobe with a request held
    wait_h(100);
    write(9'h0F0);
    wait_h(LC);
    chk("pre_rst_strobe", {8'd0, HSCRLD_b}, 9'd0);
    cyc(1'b1, 1'b1, 9'h111);
    chk("rst_hscrld", {8'd0, HSCRLD_b}, 9'd1);
    chk("rst_pending", {8'd0, pending}, 9'd1);
    chk("rst_ack", {8'd0, wr_ack}, 9'd0);
    cyc(1'b1, 1'b1, 9'h111);
    idle(HT + 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
